// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage types and default constants for the instruction fetch slice.
package if_fetch_pkg;

  localparam int unsigned ADDR_W_DEF   = 16;
  localparam int unsigned INST_W_DEF   = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [15:0] NOP_INST_DEF = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used as the fetch prefetch buffer; clear wins over push.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem read at a time,
// buffers returned words in a prefetch FIFO and drives the registered IF/ID boundary.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = ADDR_W_DEF,
  parameter int unsigned       INST_W     = INST_W_DEF,
  parameter int unsigned       FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
  parameter logic [INST_W-1:0] NOP_INST   = INST_W'(NOP_INST_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_valid_o,
  output fetch_state_t      dbg_state
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Handshake: imem_req_o stays high with a stable imem_addr_o until a cycle
  // where imem_gnt_i=1; the matching imem_rvalid_i arrives in a later cycle.

  fetch_state_t state, state_n;

  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        issued_pc;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic [ADDR_W+INST_W-1:0] fifo_head;
  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Flush only redirects the FSM; a granted fetch must still drain through DROP.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (!flush_i && fifo_count < CNT_W'(FIFO_DEPTH)) state_n = REQ;
      REQ: begin
        if (imem_gnt_i)   state_n = flush_i ? DROP : WAIT;
        else if (flush_i) state_n = IDLE;
      end
      WAIT: begin
        if (imem_rvalid_i) state_n = IDLE;
        else if (flush_i)  state_n = DROP;
      end
      DROP: if (imem_rvalid_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      issued_pc <= '0;
    end else if (flush_i) begin
      fetch_pc <= redirect_pc_i;
    end else if (state == REQ && imem_gnt_i) begin
      fetch_pc  <= fetch_pc + 1'b1;
      issued_pc <= fetch_pc;
    end
  end

  assign imem_req_o  = (state == REQ);
  assign imem_addr_o = fetch_pc;
  assign dbg_state   = state;

  assign fifo_push = (state == WAIT) && imem_rvalid_i && !flush_i;
  assign fifo_pop  = !flush_i && !stall_i && !fifo_empty;

  fetch_fifo #(
    .WIDTH (ADDR_W + INST_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush_i),
    .din   ({issued_pc, imem_rdata_i}),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The slot is reserved at issue time, so a push can never find the FIFO full.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_o    <= '0;
      id_inst_o  <= NOP_INST;
      id_valid_o <= 1'b0;
    end else if (flush_i) begin
      id_inst_o  <= NOP_INST;
      id_valid_o <= 1'b0;
    end else if (!stall_i) begin
      if (fifo_pop) begin
        id_pc_o    <= fifo_head[ADDR_W+INST_W-1:INST_W];
        id_inst_o  <= fifo_head[INST_W-1:0];
        id_valid_o <= 1'b1;
      end else begin
        id_inst_o  <= NOP_INST;
        id_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: cycle-exact directed table, reset-in-WAIT sequence and a
// random-latency memory run against a PC-sequence scoreboard.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic         clk;
  logic         rst;
  logic         stall_i;
  logic         flush_i;
  logic [15:0]  redirect_pc_i;
  logic         imem_req_o;
  logic [15:0]  imem_addr_o;
  logic         imem_gnt_i;
  logic         imem_rvalid_i;
  logic [15:0]  imem_rdata_i;
  logic [15:0]  id_pc_o;
  logic [15:0]  id_inst_o;
  logic         id_valid_o;
  fetch_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic         stall;
    logic         flush;
    logic [15:0]  redir;
    logic         gnt;
    logic         rvalid;
    logic [15:0]  rdata;
    logic         e_req;
    logic [15:0]  e_addr;
    logic         e_valid;
    logic [15:0]  e_pc;
    logic [15:0]  e_inst;
    fetch_state_t e_state;
  } vec_t;

  vec_t vq[$];

  if_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o),
    .id_valid_o    (id_valid_o),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic f, input logic [15:0] r,
                       input logic g, input logic v, input logic [15:0] d);
    stall_i       = s;
    flush_i       = f;
    redirect_pc_i = r;
    imem_gnt_i    = g;
    imem_rvalid_i = v;
    imem_rdata_i  = d;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    if (a == 16'h0000) return 16'h0445;
    if (a == 16'h0001) return 16'h0482;
    return a ^ 16'h5A00;
  endfunction

  function automatic vec_t mk(input logic s, input logic f, input logic [15:0] r,
                              input logic g, input logic v, input logic [15:0] d,
                              input logic q, input logic [15:0] a, input logic ev,
                              input logic [15:0] pc, input logic [15:0] inst,
                              input fetch_state_t st);
    vec_t x;
    x.stall = s; x.flush = f; x.redir = r; x.gnt = g; x.rvalid = v; x.rdata = d;
    x.e_req = q; x.e_addr = a; x.e_valid = ev; x.e_pc = pc; x.e_inst = inst;
    x.e_state = st;
    return x;
  endfunction

  // random-phase memory model state
  logic        pend;
  logic [15:0] pend_addr;
  int          rv_cnt;
  int          gnt_cnt;
  int          consumed;

  initial begin
    rst = 1'b1;
    drive(0, 0, 16'h0, 0, 0, 16'h0);
    step();
    step();
    chk("rst.req",   32'(imem_req_o),  32'h0);
    chk("rst.addr",  32'(imem_addr_o), 32'h0000);
    chk("rst.valid", 32'(id_valid_o),  32'h0);
    chk("rst.pc",    32'(id_pc_o),     32'h0000);
    chk("rst.inst",  32'(id_inst_o),   32'h0000);
    chk("rst.state", 32'(dbg_state),   32'(IDLE));

    // stall, flush, redir, gnt, rvalid, rdata | req, addr, valid, pc, inst, state
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0000,0,16'h0000,16'h0000,REQ));
    vq.push_back(mk(0,0,16'h0000,1,0,16'h0000, 0,16'h0001,0,16'h0000,16'h0000,WAIT));
    vq.push_back(mk(0,0,16'h0000,0,1,16'h0445, 0,16'h0001,0,16'h0000,16'h0000,IDLE));
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0001,1,16'h0000,16'h0445,REQ));
    vq.push_back(mk(0,0,16'h0000,1,0,16'h0000, 0,16'h0002,0,16'h0000,16'h0000,WAIT));
    vq.push_back(mk(0,0,16'h0000,0,1,16'h0482, 0,16'h0002,0,16'h0000,16'h0000,IDLE));
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0002,1,16'h0001,16'h0482,REQ));
    vq.push_back(mk(1,0,16'h0000,1,0,16'h0000, 0,16'h0003,1,16'h0001,16'h0482,WAIT));
    vq.push_back(mk(1,0,16'h0000,0,1,16'h5A02, 0,16'h0003,1,16'h0001,16'h0482,IDLE));
    vq.push_back(mk(1,0,16'h0000,0,0,16'h0000, 1,16'h0003,1,16'h0001,16'h0482,REQ));
    vq.push_back(mk(1,0,16'h0000,1,0,16'h0000, 0,16'h0004,1,16'h0001,16'h0482,WAIT));
    vq.push_back(mk(1,0,16'h0000,0,1,16'h5A03, 0,16'h0004,1,16'h0001,16'h0482,IDLE));
    vq.push_back(mk(1,0,16'h0000,0,0,16'h0000, 0,16'h0004,1,16'h0001,16'h0482,IDLE));
    vq.push_back(mk(1,0,16'h0000,0,0,16'h0000, 0,16'h0004,1,16'h0001,16'h0482,IDLE));
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0004,1,16'h0002,16'h5A02,IDLE));
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0004,1,16'h0003,16'h5A03,REQ));
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0004,0,16'h0003,16'h0000,REQ));
    vq.push_back(mk(0,0,16'h0000,1,0,16'h0000, 0,16'h0005,0,16'h0003,16'h0000,WAIT));
    vq.push_back(mk(0,1,16'h0040,0,0,16'h0000, 0,16'h0040,0,16'h0003,16'h0000,DROP));
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 0,16'h0040,0,16'h0003,16'h0000,DROP));
    vq.push_back(mk(0,0,16'h0000,0,1,16'h5A04, 0,16'h0040,0,16'h0003,16'h0000,IDLE));
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0040,0,16'h0003,16'h0000,REQ));
    vq.push_back(mk(0,0,16'h0000,1,0,16'h0000, 0,16'h0041,0,16'h0003,16'h0000,WAIT));
    vq.push_back(mk(0,0,16'h0000,0,1,16'h5A40, 0,16'h0041,0,16'h0003,16'h0000,IDLE));
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0041,1,16'h0040,16'h5A40,REQ));
    vq.push_back(mk(0,1,16'h0100,1,0,16'h0000, 0,16'h0100,0,16'h0040,16'h0000,DROP));
    vq.push_back(mk(0,0,16'h0000,0,1,16'h5A41, 0,16'h0100,0,16'h0040,16'h0000,IDLE));
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0100,0,16'h0040,16'h0000,REQ));
    vq.push_back(mk(0,0,16'h0000,1,0,16'h0000, 0,16'h0101,0,16'h0040,16'h0000,WAIT));
    vq.push_back(mk(0,0,16'h0000,0,1,16'h5B00, 0,16'h0101,0,16'h0040,16'h0000,IDLE));
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0101,1,16'h0100,16'h5B00,REQ));
    vq.push_back(mk(0,1,16'hFFFF,0,0,16'h0000, 0,16'hFFFF,0,16'h0100,16'h0000,IDLE));
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'hFFFF,0,16'h0100,16'h0000,REQ));
    vq.push_back(mk(0,0,16'h0000,1,0,16'h0000, 0,16'h0000,0,16'h0100,16'h0000,WAIT));
    vq.push_back(mk(0,0,16'h0000,0,1,16'hA5FF, 0,16'h0000,0,16'h0100,16'h0000,IDLE));
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0000,1,16'hFFFF,16'hA5FF,REQ));
    vq.push_back(mk(0,0,16'h0000,1,0,16'h0000, 0,16'h0001,0,16'hFFFF,16'h0000,WAIT));
    vq.push_back(mk(0,1,16'h0200,0,1,16'h0445, 0,16'h0200,0,16'hFFFF,16'h0000,IDLE));
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0200,0,16'hFFFF,16'h0000,REQ));
    vq.push_back(mk(1,0,16'h0000,1,0,16'h0000, 0,16'h0201,0,16'hFFFF,16'h0000,WAIT));
    vq.push_back(mk(1,0,16'h0000,0,1,16'h5800, 0,16'h0201,0,16'hFFFF,16'h0000,IDLE));
    vq.push_back(mk(1,0,16'h0000,0,0,16'h0000, 1,16'h0201,0,16'hFFFF,16'h0000,REQ));
    vq.push_back(mk(1,1,16'h0300,0,0,16'h0000, 0,16'h0300,0,16'hFFFF,16'h0000,IDLE));
    vq.push_back(mk(0,0,16'h0000,0,0,16'h0000, 1,16'h0300,0,16'hFFFF,16'h0000,REQ));
    vq.push_back(mk(0,0,16'h0000,1,0,16'h0000, 0,16'h0301,0,16'hFFFF,16'h0000,WAIT));

    rst = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].stall, vq[i].flush, vq[i].redir, vq[i].gnt, vq[i].rvalid, vq[i].rdata);
      step();
      chk($sformatf("v%0d.req", i),   32'(imem_req_o),  32'(vq[i].e_req));
      chk($sformatf("v%0d.addr", i),  32'(imem_addr_o), 32'(vq[i].e_addr));
      chk($sformatf("v%0d.valid", i), 32'(id_valid_o),  32'(vq[i].e_valid));
      chk($sformatf("v%0d.pc", i),    32'(id_pc_o),     32'(vq[i].e_pc));
      chk($sformatf("v%0d.inst", i),  32'(id_inst_o),   32'(vq[i].e_inst));
      chk($sformatf("v%0d.state", i), 32'(dbg_state),   32'(vq[i].e_state));
    end

    // Reset while a fetch is outstanding, then a stray rvalid right after.
    drive(0, 0, 16'h0, 0, 0, 16'h0);
    rst = 1'b1;
    step();
    chk("rw.req",   32'(imem_req_o),  32'h0);
    chk("rw.addr",  32'(imem_addr_o), 32'h0000);
    chk("rw.valid", 32'(id_valid_o),  32'h0);
    chk("rw.pc",    32'(id_pc_o),     32'h0000);
    chk("rw.inst",  32'(id_inst_o),   32'h0000);
    chk("rw.state", 32'(dbg_state),   32'(IDLE));
    rst = 1'b0;
    drive(0, 0, 16'h0, 0, 1, 16'hDEAD);
    step();
    chk("rw.stray_req", 32'(imem_req_o), 32'h1);
    drive(0, 0, 16'h0, 0, 0, 16'h0);
    step();
    chk("rw.stray_valid", 32'(id_valid_o), 32'h0);
    drive(0, 0, 16'h0, 1, 0, 16'h0);
    step();
    drive(0, 0, 16'h0, 0, 1, 16'h0445);
    step();
    drive(0, 0, 16'h0, 0, 0, 16'h0);
    step();
    chk("rw.first_valid", 32'(id_valid_o), 32'h1);
    chk("rw.first_pc",    32'(id_pc_o),    32'h0000);
    chk("rw.first_inst",  32'(id_inst_o),  32'h0445);

    // Random gnt/rvalid latency with random stall/flush against the scoreboard.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    pend     = 1'b0;
    pend_addr = '0;
    rv_cnt   = 0;
    gnt_cnt  = $urandom_range(0, 4);
    consumed = 0;
    exp_q.delete();
    exp_q.push_back(16'h0000);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        s;
      logic        f;
      logic [15:0] r;
      logic        g;
      logic        v;
      logic [15:0] d;
      logic [15:0] e;
      s = ($urandom_range(0, 99) < 30);
      f = ($urandom_range(0, 99) < 3);
      r = 16'($urandom_range(0, 65535));
      if (id_valid_o && !s && !f) begin
        e = exp_q.pop_front();
        chk($sformatf("rnd%0d.pc", cyc),   32'(id_pc_o),   32'(e));
        chk($sformatf("rnd%0d.inst", cyc), 32'(id_inst_o), 32'(mem_f(e)));
        exp_q.push_back(e + 16'h0001);
        consumed++;
      end
      if (f) begin
        exp_q.delete();
        exp_q.push_back(r);
      end
      v = 1'b0;
      d = 16'($urandom_range(0, 65535));
      if (pend) begin
        if (rv_cnt == 0) begin
          v    = 1'b1;
          d    = mem_f(pend_addr);
          pend = 1'b0;
        end else begin
          rv_cnt--;
        end
      end
      g = 1'b0;
      if (imem_req_o) begin
        if (gnt_cnt == 0) begin
          g         = 1'b1;
          pend      = 1'b1;
          pend_addr = imem_addr_o;
          rv_cnt    = $urandom_range(0, 4);
          gnt_cnt   = $urandom_range(0, 4);
        end else begin
          gnt_cnt--;
        end
      end
      drive(s, f, r, g, v, d);
      step();
    end
    checks++;
    if (consumed < 100) begin
      errors++;
      $display("FAIL rnd.progress actual=%0d expected>=100", consumed);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
